// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_pkg
// Brief    : Shared types, response codes and sizing helpers for the APB
//            request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // The counter must hold 0..TIMEOUT_CYCLES-1; keep at least one bit when disabled.
  function automatic int cnt_width(input int timeout_cycles);
    int w;
    w = clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : apb_rr_picker
// Brief    : Combinational round-robin picker; first set request at or above
//            the pointer, wrapping modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        gnt_oh_o[cand]  = 1'b1;
        gnt_idx_o       = cand;
      end
    end
  end

  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Brief    : Round-robin arbiter sharing one APB master port between NUM_REQ
//            single-beat requesters, with PREADY wait states and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [NUM_REQ-1:0]               REQ_VALID,
  output logic [NUM_REQ-1:0]               REQ_READY,
  input  logic [NUM_REQ-1:0]               REQ_WRITE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_WDATA,
  output logic [NUM_REQ-1:0]               RSP_VALID,
  output logic [DATA_WIDTH-1:0]            RSP_RDATA,
  output logic                             RSP_ERR,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic                             PWRITE,
  output logic                             PSEL,
  output logic                             PENABLE,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR,
  output logic                             BUSY,
  output logic                             TIMEOUT
);

  import apb_arb_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  apb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i     (REQ_VALID),
    .ptr_i     (rr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = RSP_OK;
    timeout_d   = 1'b0;
    REQ_READY   = '0;

    case (state_q)
      IDLE: begin
        // No accept while reset is held, so no handshake is lost to the reset.
        if (pick_any && !ARESET) begin
          REQ_READY = pick_oh;
          gnt_d     = pick_oh;
          paddr_d   = REQ_ADDR[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          pwrite_d  = REQ_WRITE[pick_idx];
          pwdata_d  = REQ_WRITE[pick_idx] ? REQ_WDATA[pick_idx*DATA_WIDTH +: DATA_WIDTH]
                                          : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          rr_d      = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = gnt_q;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR ? apb_arb_pkg::RSP_ERR : RSP_OK;
          state_d     = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = gnt_q;
          rsp_err_d   = apb_arb_pkg::RSP_ERR;
          timeout_d   = 1'b1;
          state_d     = RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign TIMEOUT   = timeout_q;
  assign BUSY      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_req_arbiter
// Brief    : Randomised self-checking bench with a transaction-level model of
//            the arbiter (round-robin pick, phase timeline, response values).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [N-1:0]    REQ_VALID = '0;
  logic [N-1:0]    REQ_READY;
  logic [N-1:0]    REQ_WRITE = '0;
  logic [N*AW-1:0] REQ_ADDR = '0;
  logic [N*DW-1:0] REQ_WDATA = '0;
  logic [N-1:0]    RSP_VALID;
  logic [DW-1:0]   RSP_RDATA;
  logic            RSP_ERR;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic            PWRITE;
  logic            PSEL;
  logic            PENABLE;
  logic [DW-1:0]   PRDATA = '0;
  logic            PREADY = 1'b0;
  logic            PSLVERR = 1'b0;
  logic            BUSY;
  logic            TIMEOUT;

  apb_req_arbiter #(
    .NUM_REQ        (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .BUSY      (BUSY),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: pending command per requester and the round-robin pointer.
  int            rr_m = 0;
  bit            pend [N];
  bit            wr_m [N];
  logic [AW-1:0] addr_m [N];
  logic [DW-1:0] wd_m [N];
  int            mode = 0;   // 0: no refill, 1: keep all pending, 2: random

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_cmd(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i]   = 1'b1;
    wr_m[i]   = w;
    addr_m[i] = a;
    wd_m[i]   = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      REQ_VALID[i]             = pend[i];
      REQ_WRITE[i]             = wr_m[i];
      REQ_ADDR[i*AW +: AW]     = addr_m[i];
      REQ_WDATA[i*DW +: DW]    = wd_m[i];
    end
  endtask

  task automatic refill();
    for (int i = 0; i < N; i++) begin
      if (mode == 1 && !pend[i]) begin
        set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end else if (mode == 2) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        else if (pend[i] && $urandom_range(0, 7) == 0)
          pend[i] = 1'b0;   // requester withdraws before being granted
      end
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  // Starts just after the edge that opens an expected IDLE cycle and ends
  // just after the edge that opens the following IDLE cycle.
  task automatic xfer(input int waits, input bit serr, input logic [DW-1:0] prd);
    int            g;
    int            nacc;
    bit            to;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    drive_reqs();
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    g = pick();
    @(negedge ACLK);
    check_eq("idle_busy", BUSY, 0);
    check_eq("idle_rsp_valid", RSP_VALID, 0);
    check_eq("idle_psel", PSEL, 0);
    if (g < 0) begin
      check_eq("idle_ready_none", REQ_READY, 0);
      @(posedge ACLK); #1;
      refill();
      return;
    end
    check_eq("grant_ready", REQ_READY, 64'(1) << g);
    a  = addr_m[g];
    w  = wr_m[g];
    wd = w ? wd_m[g] : '0;
    pend[g] = 1'b0;
    rr_m = (g + 1) % N;

    @(posedge ACLK); #1;
    refill();
    drive_reqs();
    @(negedge ACLK);
    check_eq("setup_psel", PSEL, 1);
    check_eq("setup_penable", PENABLE, 0);
    check_eq("setup_paddr", PADDR, a);
    check_eq("setup_pwrite", PWRITE, w);
    check_eq("setup_pwdata", PWDATA, wd);
    check_eq("setup_busy", BUSY, 1);
    check_eq("setup_ready", REQ_READY, 0);

    to   = (waits >= TO);
    nacc = to ? TO : waits + 1;
    for (int c = 0; c < nacc; c++) begin
      @(posedge ACLK); #1;
      PREADY  = (!to && c == nacc - 1);
      PSLVERR = PREADY ? serr : 1'b0;
      PRDATA  = PREADY ? prd : $urandom;
      @(negedge ACLK);
      check_eq("access_psel", PSEL, 1);
      check_eq("access_penable", PENABLE, 1);
      check_eq("access_paddr", PADDR, a);
      check_eq("access_pwdata", PWDATA, wd);
      check_eq("access_ready", REQ_READY, 0);
      check_eq("access_rsp_valid", RSP_VALID, 0);
    end

    @(posedge ACLK); #1;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    @(negedge ACLK);
    check_eq("resp_valid", RSP_VALID, 64'(1) << g);
    check_eq("resp_err", RSP_ERR, to ? 1 : serr);
    check_eq("resp_rdata", RSP_RDATA, (to || w) ? '0 : prd);
    check_eq("resp_timeout", TIMEOUT, to);
    check_eq("resp_psel", PSEL, 0);
    check_eq("resp_penable", PENABLE, 0);
    check_eq("resp_paddr_hold", PADDR, a);
    check_eq("resp_busy", BUSY, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic reset_during_access();
    clear_all();
    set_cmd(2, 1'b1, 32'hAAAA_0000, 32'h5555_5555);
    drive_reqs();
    @(posedge ACLK); #1;               // SETUP
    pend[2] = 1'b0;
    drive_reqs();
    @(posedge ACLK); #1;               // ACCESS, slave stalls
    set_cmd(3, 1'b0, 32'h3000_0000, '0);
    set_cmd(1, 1'b1, 32'h1000_0100, 32'h0102_0304);
    drive_reqs();
    ARESET = 1'b1;
    @(negedge ACLK);
    check_eq("pre_rst_penable", PENABLE, 1);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check_eq("rst_psel", PSEL, 0);
    check_eq("rst_penable", PENABLE, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_rsp_valid", RSP_VALID, 0);
    check_eq("rst_ready_gated", REQ_READY, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    rr_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; wr_m[i] = 1'b0; addr_m[i] = '0; wd_m[i] = '0;
    end
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_eq("rst_out_psel", PSEL, 0);
    check_eq("rst_out_penable", PENABLE, 0);
    check_eq("rst_out_paddr", PADDR, 0);
    check_eq("rst_out_pwdata", PWDATA, 0);
    check_eq("rst_out_pwrite", PWRITE, 0);
    check_eq("rst_out_rsp", {RSP_VALID, RSP_ERR, TIMEOUT, BUSY, REQ_READY}, 0);
    check_eq("rst_out_rdata", RSP_RDATA, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Single write, zero wait states.
    mode = 0;
    set_cmd(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h0);

    // All requesters continuously pending: strict rotation.
    mode = 1;
    refill();
    for (int t = 0; t < 8; t++) xfer(0, 1'b0, $urandom);

    // Read with three wait states.
    mode = 0;
    clear_all();
    set_cmd(2, 1'b0, 32'h2000_0040, 32'hFFFF_FFFF);
    xfer(3, 1'b0, 32'h1234_5678);

    // Slave error on a read.
    set_cmd(1, 1'b0, 32'h1000_0004, '0);
    xfer(1, 1'b1, 32'hCAFE_F00D);

    // Timeout, ready on the last permitted cycle, then a normal transfer.
    set_cmd(0, 1'b0, 32'h0000_0BAD, '0);
    xfer(TO, 1'b0, 32'h1111_1111);
    set_cmd(3, 1'b1, 32'h3000_0008, 32'h0BAD_CAFE);
    xfer(TO - 1, 1'b0, 32'h2222_2222);
    set_cmd(2, 1'b0, 32'h2000_0000, '0);
    xfer(0, 1'b0, 32'h3333_3333);

    // Random traffic including idle cycles and withdrawn requests.
    mode = 2;
    clear_all();
    for (int t = 0; t < 40; t++) begin
      int r;
      int waits;
      r = int'($urandom_range(0, 9));
      waits = (r < 6) ? r % 4 : ((r < 8) ? TO - 1 : TO);
      xfer(waits, 1'($urandom_range(0, 3) == 0), $urandom);
    end

    // Reset mid-transfer: pointer returns to 0, so requester 1 beats 3.
    mode = 0;
    PREADY = 1'b0;
    reset_during_access();
    xfer(0, 1'b0, 32'h4444_4444);
    xfer(2, 1'b0, 32'h5555_AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Round-robin arbiter and APB transfer sequencer that shares one APB master port between NUM_REQ on-chip requesters (bridges, DMA, debug).
Each requester issues single-beat read/write commands; the block grants one, drives the APB SETUP/ACCESS phases with PREADY wait states and a timeout, then returns a one-cycle response to the grantee.
It sits between the AXI-to-APB bridge layer and the APB peripheral fabric.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT_CYCLES, 256, max ACCESS cycles with PREADY low before forced error; 0 disables timeout

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESET  input  1  synchronous reset, active-high
REQ_VALID  input  NUM_REQ  per-requester command valid; held until REQ_READY
REQ_READY  output  NUM_REQ  one-hot accept pulse
REQ_WRITE  input  NUM_REQ  per-requester 1=write
REQ_ADDR  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
REQ_WDATA  input  NUM_REQ*DATA_WIDTH  packed write data
RSP_VALID  output  NUM_REQ  one-hot one-cycle response pulse; no backpressure
RSP_RDATA  output  DATA_WIDTH  read data, shared, valid with RSP_VALID
RSP_ERR  output  1  PSLVERR or timeout, valid with RSP_VALID
PADDR  output  ADDR_WIDTH  APB address
PWDATA  output  DATA_WIDTH  APB write data
PWRITE  output  1  APB direction
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PRDATA  input  DATA_WIDTH  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB slave error
BUSY  output  1  high in any state except IDLE
TIMEOUT  output  1  one-cycle pulse when a transfer is force-terminated

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; timeout counter 0. Reset mid-transfer aborts: PSEL/PENABLE low after the reset edge, no RSP_VALID issued.
- States: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All APB and response outputs registered.
- IDLE: if any REQ_VALID, grant g = first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ. REQ_READY[g]=1 combinationally that cycle only. Capture addr, write, wdata (wdata forced 0 for reads) and g. Go to SETUP; rr_ptr <= (g+1) mod NUM_REQ. No valid: stay IDLE, rr_ptr unchanged.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = captured values. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address/data stable.
  - PREADY=1: capture PRDATA (reads; 0 for writes) and PSLVERR, go to RESP.
  - PREADY=0: increment counter.
  - Timeout: on the TIMEOUT_CYCLES-th consecutive ACCESS cycle with PREADY=0 (TIMEOUT_CYCLES!=0), go to RESP with err=1, rdata=0, and pulse TIMEOUT.
  - PREADY=1 on that same cycle wins: normal completion.
- RESP (1 cycle): PSEL=0, PENABLE=0; RSP_VALID[g]=1, RSP_RDATA, RSP_ERR driven; next IDLE. PADDR/PWRITE/PWDATA hold last values outside transfers.
- Minimum throughput: one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP). Accept-to-response latency = 3 + wait states.
- Requesters dropping REQ_VALID before grant is legal; REQ_READY never asserts for a non-valid requester.
- Only one transfer is outstanding; REQ_READY is 0 outside IDLE.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE, SETUP, ACCESS, RESP); RSP_OK=1'b0, RSP_ERR=1'b1 constants; timeout counter width function clog2(TIMEOUT_CYCLES+1).
- One sub-module: apb_rr_picker. Combinational round-robin priority picker: inputs req vector and rr_ptr; outputs one-hot grant, grant index, any. Parameterised by NUM_REQ.
- FSM, capture registers and timeout counter stay in the top.

Test Plan:
- Req0 write addr 0x1000_0010 data 0xDEAD_BEEF, PREADY=1 -> REQ_READY[0] cycle 0; PSEL=1 PENABLE=0 cycle 1; PENABLE=1 cycle 2; RSP_VALID=4'b0001, RSP_ERR=0 cycle 3.
- All four REQ_VALID held for 8 transfers -> grant order 0,1,2,3,0,1,2,3; rr_ptr wraps; each RSP_VALID one-hot matches grant.
- Req2 read, PREADY low 3 ACCESS cycles, PRDATA=0x1234_5678 -> PADDR/PENABLE stable 4 ACCESS cycles; RSP_VALID[2] with RSP_RDATA=0x1234_5678.
- Req1 read with PSLVERR=1 at PREADY -> RSP_ERR=1, RSP_RDATA=PRDATA, TIMEOUT=0.
- TIMEOUT_CYCLES=8, PREADY stuck 0 -> after 8 ACCESS cycles TIMEOUT pulse; RSP_ERR=1, RSP_RDATA=0; next request serviced normally.
- ARESET asserted during ACCESS -> next edge PSEL=0, BUSY=0, no RSP_VALID; after release, req3 granted first only if req0..2 are idle (rr_ptr=0).
